nios_debug_scan_master: RTL and testbench
=========================================

Name: nios_debug_scan_master

Overview:
- Single-clock JTAG scan initiator for the Nios II debug slave's virtual-JTAG interface; the driving end of the link that the debug slave's TCK-side logic receives.
- Accepts one debug command (IR value plus data word) and generates the full TAP virtual-state sequence: tck, tdi, ir_in, uir/cdr/sdr/e1dr strobes.
- Returns the shifted-out data word; used by on-chip self-test and as a simulation stimulus source for the debug slave.

Parameters:
- SR_WIDTH, 38, data shift-register length in bits.
- IR_WIDTH, 2, virtual instruction register width.
- TCK_DIV, 2, clk cycles per tck half-period; legal range ≥1.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  synchronous active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  block can accept a command.
- cmd_ir  in  IR_WIDTH  instruction to load.
- cmd_data  in  SR_WIDTH  word to shift in, LSB first.
- rsp_valid  out  1  response word available.
- rsp_ready  in  1  response consumed.
- rsp_data  out  SR_WIDTH  captured tdo bits; first bit shifted is at [0].
- tck  out  1  generated test clock.
- tdi  out  1  serial data to slave.
- tdo  in  1  serial data from slave.
- ir_in  out  IR_WIDTH  current virtual instruction.
- jtag_state_rti  out  1  run-test-idle indication.
- vs_uir, vs_cdr, vs_sdr, vs_e1dr  out  1 each  virtual-state strobes.

Behaviour:
- Reset (reset_n low at clk edge) forces all of the following, aborting any scan in progress and dropping any pending response:
  - state IDLE;
  - tck=0, tdi=0, ir_in=0;
  - all vs_* = 0, jtag_state_rti=1;
  - cmd_ready=1, rsp_valid=0, rsp_data=0.
- Handshakes:
  - Command accepted on the clk edge where cmd_valid && cmd_ready.
  - cmd_ready=1 only in IDLE with rsp_valid=0.
  - rsp_valid stays high, with rsp_data stable, until the clk edge where rsp_ready=1; it then clears.
- tck generation:
  - A "tck period" is 2*TCK_DIV clk cycles: tck low for the first TCK_DIV cycles, high for the next TCK_DIV.
  - tck is held 0 outside scan states.
  - The state strobes and tdi change only at period start, i.e. coincident with tck falling or low.
  - tdo is sampled in the clk cycle in which tck rises.
- States (each scan state lasts a whole number of tck periods):
  - IDLE: jtag_state_rti=1. On accept, latch cmd_ir/cmd_data and go to UIR next cycle.
  - UIR: 1 period; ir_in <= latched cmd_ir at period start; vs_uir=1. ir_in then holds until the next UIR or reset.
  - CDR: 1 period; vs_cdr=1.
  - SDR: SR_WIDTH periods; vs_sdr=1.
    - In period k (k=0..SR_WIDTH-1), tdi = data bit k.
    - The tdo sampled at the rising edge of period k goes to rsp shift register: shift right, new bit into MSB.
    - After SR_WIDTH samples, bit 0 of rsp_data holds the first sample.
  - E1DR: 1 period; vs_e1dr=1, tdi=0.
  - RSP: rsp_valid=1, tck=0, jtag_state_rti=1; return to IDLE on rsp_ready.
- Exactly one vs_* strobe is high in each scan state; none are high in IDLE/RSP.
- Latency:
  - First UIR cycle is the cycle after the acceptance edge.
  - rsp_valid rises (SR_WIDTH+3)*2*TCK_DIV+1 cycles after the acceptance edge; with defaults, 165 cycles.
- Boundaries:
  - cmd_valid held during a scan is ignored (cmd_ready=0).
  - rsp_ready asserted with rsp_valid=0 has no effect.
  - Back-to-back commands: a new accept is possible the cycle after the rsp handshake.
  - Internal period counter and bit counter wrap only via state change; no free-running overflow.

Test Plan:
- Reset values: hold reset_n=0 for 3 cycles -> tck=0, all vs_*=0, jtag_state_rti=1, cmd_ready=1, rsp_valid=0, ir_in=0.
- Basic scan:
  - Stimulus: bench slave model captures 38'h15_DEADBEEF at the CDR rising edge and shifts sr={tdi,sr[37:1]} with tdo=sr[0]; send cmd_ir=2'b01, cmd_data=38'h2A_12345678.
  - Required: ir_in=01, the slave sees 38'h2A_12345678 after E1DR, rsp_data=38'h15_DEADBEEF, rsp_valid rises exactly 165 cycles after accept.
- Strobe timing: count clk cycles per strobe -> vs_uir 4, vs_cdr 4, vs_sdr 152, vs_e1dr 4 (defaults); 38 tck rising edges while vs_sdr=1.
- Back-pressure: rsp_ready=0 for 20 cycles after rsp_valid, with cmd_valid held high -> rsp_data stable, cmd_ready=0; after the handshake, the second command is accepted the next cycle.
- Reset mid-shift: assert reset_n=0 during SDR bit 17 -> next cycle idle values as in the reset test, no rsp_valid; a fresh command then completes normally.
- TCK_DIV=1: repeat the basic scan -> same rsp_data, rsp_valid after 83 cycles, tck toggling every clk cycle during scan.

Source files
------------

// File: rtl/nios_debug_scan_master.sv
// JTAG scan initiator for the Nios II debug slave virtual-JTAG port.
// Runs one UIR/CDR/SDR/E1DR sequence per command and returns the captured tdo word.
module nios_debug_scan_master #(
  parameter int SR_WIDTH = 38,
  parameter int IR_WIDTH = 2,
  parameter int TCK_DIV  = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [IR_WIDTH-1:0] cmd_ir,
  input  logic [SR_WIDTH-1:0] cmd_data,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [SR_WIDTH-1:0] rsp_data,
  output logic                tck,
  output logic                tdi,
  input  logic                tdo,
  output logic [IR_WIDTH-1:0] ir_in,
  output logic                jtag_state_rti,
  output logic                vs_uir,
  output logic                vs_cdr,
  output logic                vs_sdr,
  output logic                vs_e1dr
);

  localparam int CNT_W = $clog2(2 * TCK_DIV);
  localparam int BIT_W = (SR_WIDTH > 1) ? $clog2(SR_WIDTH) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(2 * TCK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_RISE = CNT_W'(TCK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_HIGH = CNT_W'(TCK_DIV);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(SR_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_UIR,
    S_CDR,
    S_SDR,
    S_E1DR,
    S_RSP
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [CNT_W-1:0]    cnt;
  logic [BIT_W-1:0]    bit_cnt;
  logic [SR_WIDTH-1:0] data_q;

  logic scan;
  logic period_end;
  logic sample;
  logic last_bit;
  logic accept;
  logic rsp_done;

  assign scan       = (state == S_UIR) || (state == S_CDR) ||
                      (state == S_SDR) || (state == S_E1DR);
  assign period_end = scan && (cnt == CNT_LAST);
  // tdo is taken on the clk edge that raises tck, before the slave shifts.
  assign sample     = (state == S_SDR) && (cnt == CNT_RISE);
  assign last_bit   = (bit_cnt == BIT_LAST);
  assign accept     = cmd_valid && cmd_ready;
  assign rsp_done   = rsp_valid && rsp_ready;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = S_UIR;
      S_UIR:   if (period_end) state_nxt = S_CDR;
      S_CDR:   if (period_end) state_nxt = S_SDR;
      S_SDR:   if (period_end && last_bit) state_nxt = S_E1DR;
      S_E1DR:  if (period_end) state_nxt = S_RSP;
      S_RSP:   if (rsp_done) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Period and bit counters only advance inside the states that own them.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt     <= '0;
      bit_cnt <= '0;
    end else begin
      if (!scan || period_end) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
      if (state != S_SDR) begin
        bit_cnt <= '0;
      end else if (period_end && !last_bit) begin
        bit_cnt <= bit_cnt + BIT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      data_q <= cmd_data;
    end else if ((state == S_SDR) && period_end) begin
      data_q <= {1'b0, data_q[SR_WIDTH-1:1]};
    end
  end

  // ir_in loads on the accept edge so it is valid from the first UIR cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ir_in <= '0;
    end else if (accept) begin
      ir_in <= cmd_ir;
    end
  end

  // The response is registered one cycle after the scan closes with tck low.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      if ((state == S_RSP) && !rsp_valid) begin
        rsp_valid <= 1'b1;
      end else if (rsp_done) begin
        rsp_valid <= 1'b0;
      end
      if (sample) begin
        rsp_data <= {tdo, rsp_data[SR_WIDTH-1:1]};
      end
    end
  end

  assign cmd_ready      = (state == S_IDLE) && !rsp_valid;
  assign tck            = scan && (cnt >= CNT_HIGH);
  assign tdi            = (state == S_SDR) ? data_q[0] : 1'b0;
  assign jtag_state_rti = (state == S_IDLE) || (state == S_RSP);
  assign vs_uir         = (state == S_UIR);
  assign vs_cdr         = (state == S_CDR);
  assign vs_sdr         = (state == S_SDR);
  assign vs_e1dr        = (state == S_E1DR);

endmodule

// File: tb/tb_nios_debug_scan_master.sv
// Bench for nios_debug_scan_master: behavioural virtual-JTAG slave per DUT,
// randomized commands, timing/strobe monitors and a TCK_DIV=1 instance.
module tb_nios_debug_scan_master;
  localparam int SRW = 38;
  localparam int IRW = 2;
  localparam int LAT2 = (SRW + 3) * 2 * 2 + 1;
  localparam int LAT1 = (SRW + 3) * 2 * 1 + 1;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic           cmd_valid = 1'b0, rsp_ready = 1'b0;
  logic [IRW-1:0] cmd_ir = '0;
  logic [SRW-1:0] cmd_data = '0;
  logic           cmd_ready, rsp_valid, tck, tdi, tdo, jtag_state_rti;
  logic           vs_uir, vs_cdr, vs_sdr, vs_e1dr;
  logic [IRW-1:0] ir_in;
  logic [SRW-1:0] rsp_data;

  logic           u1_cmd_valid = 1'b0, u1_rsp_ready = 1'b0;
  logic [IRW-1:0] u1_cmd_ir = '0;
  logic [SRW-1:0] u1_cmd_data = '0;
  logic           u1_cmd_ready, u1_rsp_valid, u1_tck, u1_tdi, u1_tdo, u1_rti;
  logic           u1_vs_uir, u1_vs_cdr, u1_vs_sdr, u1_vs_e1dr;
  logic [IRW-1:0] u1_ir_in;
  logic [SRW-1:0] u1_rsp_data;

  nios_debug_scan_master #(.SR_WIDTH(SRW), .IR_WIDTH(IRW), .TCK_DIV(2)) dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_ir(cmd_ir), .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .tck(tck), .tdi(tdi), .tdo(tdo), .ir_in(ir_in),
    .jtag_state_rti(jtag_state_rti), .vs_uir(vs_uir), .vs_cdr(vs_cdr),
    .vs_sdr(vs_sdr), .vs_e1dr(vs_e1dr));

  nios_debug_scan_master #(.SR_WIDTH(SRW), .IR_WIDTH(IRW), .TCK_DIV(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .cmd_valid(u1_cmd_valid), .cmd_ready(u1_cmd_ready),
    .cmd_ir(u1_cmd_ir), .cmd_data(u1_cmd_data), .rsp_valid(u1_rsp_valid),
    .rsp_ready(u1_rsp_ready), .rsp_data(u1_rsp_data), .tck(u1_tck), .tdi(u1_tdi),
    .tdo(u1_tdo), .ir_in(u1_ir_in), .jtag_state_rti(u1_rti), .vs_uir(u1_vs_uir),
    .vs_cdr(u1_vs_cdr), .vs_sdr(u1_vs_sdr), .vs_e1dr(u1_vs_e1dr));

  // Slave models: capture at CDR rising tck, shift right with tdi into MSB.
  logic [SRW-1:0] s_cap = '0, s_sr = '0;
  always @(posedge tck) begin
    if (vs_cdr) s_sr <= s_cap;
    else if (vs_sdr) s_sr <= {tdi, s_sr[SRW-1:1]};
  end
  assign tdo = s_sr[0];

  logic [SRW-1:0] u1_cap = '0, u1_sr = '0;
  always @(posedge u1_tck) begin
    if (u1_vs_cdr) u1_sr <= u1_cap;
    else if (u1_vs_sdr) u1_sr <= {u1_tdi, u1_sr[SRW-1:1]};
  end
  assign u1_tdo = u1_sr[0];

  // Monotonic monitors; tests work on differences.
  int n_uir = 0, n_cdr = 0, n_sdr = 0, n_e1dr = 0, n_sdr_rise = 0, n_viol = 0;
  always @(negedge clk) begin
    if (vs_uir) n_uir++;
    if (vs_cdr) n_cdr++;
    if (vs_sdr) n_sdr++;
    if (vs_e1dr) n_e1dr++;
    if (!jtag_state_rti && ($countones({vs_uir, vs_cdr, vs_sdr, vs_e1dr}) != 1)) n_viol++;
    if (jtag_state_rti && (tck || vs_uir || vs_cdr || vs_sdr || vs_e1dr)) n_viol++;
    if (vs_e1dr && tdi) n_viol++;
  end
  always @(posedge tck) if (vs_sdr) n_sdr_rise++;

  int u1_scan_cyc = 0, u1_tog_err = 0;
  logic u1_prev_tck = 1'b0, u1_prev_scan = 1'b0;
  always @(negedge clk) begin
    if (!u1_rti) begin
      u1_scan_cyc++;
      if (u1_prev_scan && (u1_tck == u1_prev_tck)) u1_tog_err++;
      if (!u1_prev_scan && u1_tck) u1_tog_err++;
    end
    u1_prev_tck  = u1_tck;
    u1_prev_scan = !u1_rti;
  end

  function automatic logic [SRW-1:0] rand_word();
    logic [63:0] w;
    w = {$urandom, $urandom};
    return w[SRW-1:0];
  endfunction

  task automatic start_cmd(input logic [IRW-1:0] ir, input logic [SRW-1:0] d,
                           input logic [SRW-1:0] cap, output int lat);
    int t;
    @(negedge clk);
    s_cap = cap; cmd_ir = ir; cmd_data = d; cmd_valid = 1'b1;
    t = 0;
    while (!cmd_ready && t < 400) begin @(negedge clk); t++; end
    if (!cmd_ready) begin
      checks++; failures++;
      $display("FAIL accept_timeout cmd_ready=%b required=1", cmd_ready);
      cmd_valid = 1'b0; lat = -1;
      return;
    end
    @(posedge clk); #1 cmd_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 1000) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic handshake();
    @(negedge clk); rsp_ready = 1'b1;
    @(posedge clk); #1 rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk); reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if ({tck, tdi, vs_uir, vs_cdr, vs_sdr, vs_e1dr} !== 6'b0) begin failures++;
      $display("FAIL reset_outputs got=%b required=000000", {tck, tdi, vs_uir, vs_cdr, vs_sdr, vs_e1dr}); end
    checks++; if ({jtag_state_rti, cmd_ready, rsp_valid} !== 3'b110) begin failures++;
      $display("FAIL reset_ctrl got=%b required=110", {jtag_state_rti, cmd_ready, rsp_valid}); end
    checks++; if (ir_in !== 2'b00 || rsp_data !== '0) begin failures++;
      $display("FAIL reset_regs ir_in=%b rsp_data=%h required 0", ir_in, rsp_data); end
    checks++; if ({u1_tck, u1_rti, u1_cmd_ready, u1_rsp_valid} !== 4'b0110) begin failures++;
      $display("FAIL reset_div1 got=%b required=0110", {u1_tck, u1_rti, u1_cmd_ready, u1_rsp_valid}); end
    @(negedge clk); reset_n = 1'b1;
    // rsp_ready without a pending response must do nothing.
    rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    rsp_ready = 1'b0;
    checks++; if ({rsp_valid, cmd_ready, jtag_state_rti} !== 3'b011) begin failures++;
      $display("FAIL stray_rsp_ready got=%b required=011", {rsp_valid, cmd_ready, jtag_state_rti}); end
  endtask

  task automatic test_basic();
    int lat;
    start_cmd(2'b01, 38'h2A_12345678, 38'h15_DEADBEEF, lat);
    checks++; if (lat !== LAT2) begin failures++;
      $display("FAIL basic_latency got=%0d required=%0d", lat, LAT2); end
    checks++; if (ir_in !== 2'b01) begin failures++;
      $display("FAIL basic_ir got=%b required=01", ir_in); end
    checks++; if (s_sr !== 38'h2A_12345678) begin failures++;
      $display("FAIL basic_slave_word got=%h required=%h", s_sr, 38'h2A_12345678); end
    checks++; if (rsp_data !== 38'h15_DEADBEEF) begin failures++;
      $display("FAIL basic_rsp_data got=%h required=%h", rsp_data, 38'h15_DEADBEEF); end
    handshake();
    checks++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin failures++;
      $display("FAIL basic_handshake rsp_valid=%b cmd_ready=%b required 0/1", rsp_valid, cmd_ready); end
  endtask

  task automatic test_strobes();
    int lat, b_uir, b_cdr, b_sdr, b_e1dr, b_rise, b_viol;
    b_uir = n_uir; b_cdr = n_cdr; b_sdr = n_sdr; b_e1dr = n_e1dr;
    b_rise = n_sdr_rise; b_viol = n_viol;
    start_cmd(2'($urandom), rand_word(), rand_word(), lat);
    handshake();
    checks++; if (n_uir - b_uir !== 4) begin failures++;
      $display("FAIL strobe_uir got=%0d required=4", n_uir - b_uir); end
    checks++; if (n_cdr - b_cdr !== 4) begin failures++;
      $display("FAIL strobe_cdr got=%0d required=4", n_cdr - b_cdr); end
    checks++; if (n_sdr - b_sdr !== SRW * 4) begin failures++;
      $display("FAIL strobe_sdr got=%0d required=%0d", n_sdr - b_sdr, SRW * 4); end
    checks++; if (n_e1dr - b_e1dr !== 4) begin failures++;
      $display("FAIL strobe_e1dr got=%0d required=4", n_e1dr - b_e1dr); end
    checks++; if (n_sdr_rise - b_rise !== SRW) begin failures++;
      $display("FAIL sdr_tck_rises got=%0d required=%0d", n_sdr_rise - b_rise, SRW); end
    checks++; if (n_viol - b_viol !== 0) begin failures++;
      $display("FAIL strobe_rules violations=%0d required=0", n_viol - b_viol); end
  endtask

  task automatic test_random();
    int lat;
    logic [IRW-1:0] ir;
    logic [SRW-1:0] d, cap;
    for (int i = 0; i < 4; i++) begin
      ir = 2'($urandom); d = rand_word(); cap = rand_word();
      start_cmd(ir, d, cap, lat);
      checks++; if (lat !== LAT2 || ir_in !== ir) begin failures++;
        $display("FAIL rand%0d_lat_ir lat=%0d ir=%b required %0d/%b", i, lat, ir_in, LAT2, ir); end
      checks++; if (s_sr !== d) begin failures++;
        $display("FAIL rand%0d_slave_word got=%h required=%h", i, s_sr, d); end
      checks++; if (rsp_data !== cap) begin failures++;
        $display("FAIL rand%0d_rsp_data got=%h required=%h", i, rsp_data, cap); end
      handshake();
    end
  endtask

  task automatic test_back_pressure();
    int lat, bad;
    logic [SRW-1:0] cap_a, d_b, cap_b;
    logic [IRW-1:0] ir_b;
    cap_a = rand_word(); d_b = rand_word(); cap_b = rand_word(); ir_b = 2'b10;
    start_cmd(2'b11, rand_word(), cap_a, lat);
    @(negedge clk);
    s_cap = cap_b; cmd_ir = ir_b; cmd_data = d_b; cmd_valid = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (rsp_data !== cap_a || cmd_ready !== 1'b0 || rsp_valid !== 1'b1) bad++;
      @(negedge clk);
    end
    checks++; if (bad !== 0) begin failures++;
      $display("FAIL bp_hold bad_cycles=%0d required=0", bad); end
    rsp_ready = 1'b1;
    @(posedge clk); #1 rsp_ready = 1'b0;
    checks++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin failures++;
      $display("FAIL bp_release rsp_valid=%b cmd_ready=%b required 0/1", rsp_valid, cmd_ready); end
    @(posedge clk); #1;
    checks++; if (vs_uir !== 1'b1 || cmd_ready !== 1'b0 || ir_in !== ir_b) begin failures++;
      $display("FAIL bp_next_accept vs_uir=%b cmd_ready=%b ir=%b required 1/0/%b", vs_uir, cmd_ready, ir_in, ir_b); end
    cmd_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 1000) begin @(posedge clk); #1; lat++; end
    checks++; if (lat !== LAT2 || rsp_data !== cap_b || s_sr !== d_b) begin failures++;
      $display("FAIL bp_second lat=%0d rsp=%h slave=%h required %0d/%h/%h", lat, rsp_data, s_sr, LAT2, cap_b, d_b); end
    handshake();
  endtask

  task automatic test_reset_mid();
    int base, t, lat;
    logic [SRW-1:0] d, cap;
    @(negedge clk);
    s_cap = rand_word(); cmd_ir = 2'b11; cmd_data = rand_word(); cmd_valid = 1'b1;
    @(posedge clk); #1 cmd_valid = 1'b0;
    base = n_sdr_rise; t = 0;
    while ((n_sdr_rise - base) < 18 && t < 1000) begin @(negedge clk); t++; end
    checks++; if (vs_sdr !== 1'b1) begin failures++;
      $display("FAIL mid_reach_sdr vs_sdr=%b required=1", vs_sdr); end
    @(negedge clk); reset_n = 1'b0;
    @(posedge clk); #1;
    checks++; if ({tck, vs_uir, vs_cdr, vs_sdr, vs_e1dr, jtag_state_rti, cmd_ready, rsp_valid} !== 8'b00000110
                  || ir_in !== 2'b00) begin failures++;
      $display("FAIL mid_reset_idle got=%b ir=%b required=00000110/00",
               {tck, vs_uir, vs_cdr, vs_sdr, vs_e1dr, jtag_state_rti, cmd_ready, rsp_valid}, ir_in); end
    @(negedge clk); reset_n = 1'b1;
    t = 0;
    for (int i = 0; i < 200; i++) begin if (rsp_valid !== 1'b0) t++; @(negedge clk); end
    checks++; if (t !== 0) begin failures++;
      $display("FAIL mid_no_rsp rsp_valid_cycles=%0d required=0", t); end
    d = rand_word(); cap = rand_word();
    start_cmd(2'b01, d, cap, lat);
    checks++; if (lat !== LAT2 || rsp_data !== cap || s_sr !== d) begin failures++;
      $display("FAIL mid_fresh lat=%0d rsp=%h slave=%h required %0d/%h/%h", lat, rsp_data, s_sr, LAT2, cap, d); end
    handshake();
  endtask

  task automatic test_tck_div1();
    int lat, t, b_cyc, b_err;
    b_cyc = u1_scan_cyc; b_err = u1_tog_err;
    @(negedge clk);
    u1_cap = 38'h15_DEADBEEF; u1_cmd_ir = 2'b01; u1_cmd_data = 38'h2A_12345678; u1_cmd_valid = 1'b1;
    t = 0;
    while (!u1_cmd_ready && t < 400) begin @(negedge clk); t++; end
    @(posedge clk); #1 u1_cmd_valid = 1'b0;
    lat = 0;
    while (!u1_rsp_valid && lat < 1000) begin @(posedge clk); #1; lat++; end
    checks++; if (lat !== LAT1) begin failures++;
      $display("FAIL div1_latency got=%0d required=%0d", lat, LAT1); end
    checks++; if (u1_rsp_data !== 38'h15_DEADBEEF || u1_sr !== 38'h2A_12345678 || u1_ir_in !== 2'b01) begin failures++;
      $display("FAIL div1_data rsp=%h slave=%h ir=%b", u1_rsp_data, u1_sr, u1_ir_in); end
    checks++; if (u1_scan_cyc - b_cyc !== (SRW + 3) * 2 || u1_tog_err - b_err !== 0) begin failures++;
      $display("FAIL div1_tck scan_cycles=%0d toggle_errors=%0d required %0d/0",
               u1_scan_cyc - b_cyc, u1_tog_err - b_err, (SRW + 3) * 2); end
    @(negedge clk); u1_rsp_ready = 1'b1;
    @(posedge clk); #1 u1_rsp_ready = 1'b0;
    checks++; if (u1_rsp_valid !== 1'b0 || u1_cmd_ready !== 1'b1) begin failures++;
      $display("FAIL div1_handshake rsp_valid=%b cmd_ready=%b required 0/1", u1_rsp_valid, u1_cmd_ready); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_strobes();
    test_random();
    test_back_pressure();
    test_reset_mid();
    test_tck_div1();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
